// File: rtl/exe_stage_pkg.sv
// Shared widths, ALU opcode bit positions and bus layouts for the execute stage.
// Imported by exe_stage and its alu sub-module.
package exe_stage_pkg;

    localparam int ALU_OP_WD       = 13;
    localparam int DS_TO_ES_BUS_WD = 149;
    localparam int ES_TO_MS_BUS_WD = 71;
    localparam int ES_FWD_BUS_WD   = 39;

    // One-hot alu_op bit indices
    localparam int OP_ADD  = 0;
    localparam int OP_SUB  = 1;
    localparam int OP_SLT  = 2;
    localparam int OP_SLTU = 3;
    localparam int OP_AND  = 4;
    localparam int OP_NOR  = 5;
    localparam int OP_OR   = 6;
    localparam int OP_XOR  = 7;
    localparam int OP_SLL  = 8;
    localparam int OP_SRL  = 9;
    localparam int OP_SRA  = 10;
    localparam int OP_LUI  = 11;
    localparam int OP_MUL  = 12;

    typedef enum logic {
        IDLE = 1'b0,
        DONE = 1'b1
    } mul_state_t;

    typedef struct packed {
        logic [ALU_OP_WD-1:0] alu_op;
        logic [31:0]          src1;
        logic [31:0]          src2;
        logic [31:0]          rkd_value;
        logic [4:0]           dest;
        logic                 gr_we;
        logic                 mem_we;
        logic                 res_from_mem;
        logic [31:0]          pc;
    } ds_to_es_t;

endpackage

// File: rtl/exe_stage_alu.sv
// Combinational ALU selected by a one-hot opcode; mul yields the low 32 product bits.
// Arithmetic wraps silently at 32 bits.
module alu
    import exe_stage_pkg::*;
(
    input  logic [ALU_OP_WD-1:0] alu_op,
    input  logic [31:0]          src1,
    input  logic [31:0]          src2,
    output logic [31:0]          result
);

    logic        use_sub;
    logic [31:0] adder_b;
    logic [32:0] adder_full;
    logic [31:0] sum;
    logic        slt_bit;
    logic        sltu_bit;
    logic [31:0] sll_res;
    logic [31:0] srl_res;
    logic [31:0] sra_res;
    logic [31:0] mul_res;

    // sub/slt/sltu share the adder as src1 + ~src2 + 1
    assign use_sub    = alu_op[OP_SUB] | alu_op[OP_SLT] | alu_op[OP_SLTU];
    assign adder_b    = use_sub ? ~src2 : src2;
    assign adder_full = {1'b0, src1} + {1'b0, adder_b} + {32'd0, use_sub};
    assign sum        = adder_full[31:0];

    assign slt_bit  = (src1[31] & ~src2[31]) | (~(src1[31] ^ src2[31]) & sum[31]);
    assign sltu_bit = ~adder_full[32];

    assign sll_res = src1 << src2[4:0];
    assign srl_res = src1 >> src2[4:0];
    assign sra_res = $signed(src1) >>> src2[4:0];
    assign mul_res = src1 * src2;

    assign result = ({32{alu_op[OP_ADD] | alu_op[OP_SUB]}} & sum)
                  | ({32{alu_op[OP_SLT]}}  & {31'd0, slt_bit})
                  | ({32{alu_op[OP_SLTU]}} & {31'd0, sltu_bit})
                  | ({32{alu_op[OP_AND]}}  & (src1 & src2))
                  | ({32{alu_op[OP_NOR]}}  & ~(src1 | src2))
                  | ({32{alu_op[OP_OR]}}   & (src1 | src2))
                  | ({32{alu_op[OP_XOR]}}  & (src1 ^ src2))
                  | ({32{alu_op[OP_SLL]}}  & sll_res)
                  | ({32{alu_op[OP_SRL]}}  & srl_res)
                  | ({32{alu_op[OP_SRA]}}  & sra_res)
                  | ({32{alu_op[OP_LUI]}}  & src2)
                  | ({32{alu_op[OP_MUL]}}  & mul_res);

endmodule

// File: rtl/exe_stage.sv
// Pipeline execute stage: one-entry holding register, ALU, two-cycle multiply,
// data memory request generation and forwarding bus toward decode.
module exe_stage
    import exe_stage_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ds_to_es_valid,
    input  logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
    output logic                       es_allowin,
    input  logic                       ms_allowin,
    output logic                       es_to_ms_valid,
    output logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic [ES_FWD_BUS_WD-1:0]   es_fwd_bus,
    output logic                       data_sram_en,
    output logic [3:0]                 data_sram_we,
    output logic [31:0]                data_sram_addr,
    output logic [31:0]                data_sram_wdata
);

    logic                       es_valid;
    logic [DS_TO_ES_BUS_WD-1:0] es_bus_r;
    ds_to_es_t                  es;
    mul_state_t                 mul_done;
    mul_state_t                 mul_next;
    logic [31:0]                mul_res_r;
    logic [31:0]                alu_result;
    logic [31:0]                es_result;
    logic                       is_mul;
    logic                       es_ready_go;
    logic                       handoff;

    assign es          = ds_to_es_t'(es_bus_r);
    assign is_mul      = es.alu_op[OP_MUL];
    assign es_ready_go = !is_mul || (mul_done == DONE);
    assign es_allowin  = !es_valid || (es_ready_go && ms_allowin);
    assign es_to_ms_valid = es_valid && es_ready_go;
    assign handoff     = es_to_ms_valid && ms_allowin;

    alu u_alu (
        .alu_op (es.alu_op),
        .src1   (es.src1),
        .src2   (es.src2),
        .result (alu_result)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            es_valid <= 1'b0;
        end else if (es_allowin) begin
            es_valid <= ds_to_es_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            es_bus_r <= '0;
        end else if (ds_to_es_valid && es_allowin) begin
            es_bus_r <= ds_to_es_bus;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mul_done <= IDLE;
        end else begin
            mul_done <= mul_next;
        end
    end

    always_comb begin
        mul_next = mul_done;
        case (mul_done)
            IDLE:    if (es_valid && is_mul) mul_next = DONE;
            DONE:    if (handoff)            mul_next = IDLE;
            default: mul_next = IDLE;
        endcase
    end

    // The product is sampled during the first mul cycle and offered in the second
    always_ff @(posedge clk) begin
        if (reset) begin
            mul_res_r <= '0;
        end else if ((mul_done == IDLE) && es_valid && is_mul) begin
            mul_res_r <= alu_result;
        end
    end

    assign es_result = is_mul ? mul_res_r : alu_result;

    assign es_to_ms_bus = {es.res_from_mem, es.gr_we, es.dest, es_result, es.pc};
    assign es_fwd_bus   = {es_valid && es.gr_we, es_valid && es.res_from_mem, es.dest, es_result};

    assign data_sram_en    = es_valid && (es.mem_we || es.res_from_mem) && ms_allowin;
    assign data_sram_we    = {4{es.mem_we && data_sram_en}};
    assign data_sram_addr  = alu_result;
    assign data_sram_wdata = es.rkd_value;

endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage: opcode vector table, hand-written handshake
// sequences and a randomized run against a cycle-level behavioural model.
module tb_exe_stage;

    logic         clk = 1'b0;
    logic         reset;
    logic         ds_to_es_valid;
    logic [148:0] ds_to_es_bus;
    logic         es_allowin;
    logic         ms_allowin;
    logic         es_to_ms_valid;
    logic [70:0]  es_to_ms_bus;
    logic [38:0]  es_fwd_bus;
    logic         data_sram_en;
    logic [3:0]   data_sram_we;
    logic [31:0]  data_sram_addr;
    logic [31:0]  data_sram_wdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    exe_stage dut (
        .clk             (clk),
        .reset           (reset),
        .ds_to_es_valid  (ds_to_es_valid),
        .ds_to_es_bus    (ds_to_es_bus),
        .es_allowin      (es_allowin),
        .ms_allowin      (ms_allowin),
        .es_to_ms_valid  (es_to_ms_valid),
        .es_to_ms_bus    (es_to_ms_bus),
        .es_fwd_bus      (es_fwd_bus),
        .data_sram_en    (data_sram_en),
        .data_sram_we    (data_sram_we),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [148:0] mk_bus(input logic [12:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] rkd,
                                            input logic [4:0] dest, input logic gr_we,
                                            input logic mem_we, input logic rfm,
                                            input logic [31:0] pc);
        return {op, a, b, rkd, dest, gr_we, mem_we, rfm, pc};
    endfunction

    // Reference ALU from the opcode definitions using plain integer arithmetic
    function automatic logic [31:0] ref_alu(input logic [12:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] p;
        int signed   sa;
        int signed   sb;
        sa = a;
        sb = b;
        p  = 64'(a) * 64'(b);
        case (op)
            13'h0001: return a + b;
            13'h0002: return a - b;
            13'h0004: return (sa < sb) ? 32'd1 : 32'd0;
            13'h0008: return (a < b) ? 32'd1 : 32'd0;
            13'h0010: return a & b;
            13'h0020: return ~(a | b);
            13'h0040: return a | b;
            13'h0080: return a ^ b;
            13'h0100: return a << b[4:0];
            13'h0200: return a >> b[4:0];
            13'h0400: return 32'(sa >>> b[4:0]);
            13'h0800: return b;
            13'h1000: return p[31:0];
            default:  return 32'd0;
        endcase
    endfunction

    // Drive inputs just after the falling edge, then let outputs settle before sampling
    task automatic step(input logic v, input logic [148:0] bus, input logic msa);
        @(negedge clk);
        ds_to_es_valid = v;
        ds_to_es_bus   = bus;
        ms_allowin     = msa;
        #2;
    endtask

    typedef struct {
        string       name;
        logic [12:0] op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[14];

    // Randomized-run model state: the instruction resident in the stage, if any
    logic        m_valid;
    logic        m_mul;
    int          m_cyc;
    logic [70:0] m_payload;
    logic        m_memop;
    logic        m_mem_we;
    logic        m_gr_we;
    logic        m_rfm;
    logic [31:0] m_rkd;
    logic [4:0]  m_dest;

    initial begin
        logic [70:0] held;
        logic        md;
        logic        seen;

        reset          = 1'b1;
        ds_to_es_valid = 1'b0;
        ds_to_es_bus   = '0;
        ms_allowin     = 1'b1;
        repeat (2) @(posedge clk);
        step(0, '0, 1);
        reset = 1'b0;
        step(0, '0, 1);
        chk("rst_allowin", 128'(es_allowin), 128'(1));
        chk("rst_to_ms_valid", 128'(es_to_ms_valid), 128'(0));
        chk("rst_sram_en", 128'(data_sram_en), 128'(0));
        chk("rst_sram_we", 128'(data_sram_we), 128'(0));
        chk("rst_fwd_flags", 128'(es_fwd_bus[38:37]), 128'(0));

        vecs[0]  = '{"add",  13'h0001, 32'd5,         32'd7,         32'd12};
        vecs[1]  = '{"sub",  13'h0002, 32'd5,         32'd7,         32'hFFFF_FFFE};
        vecs[2]  = '{"slt",  13'h0004, 32'hFFFF_FFFF, 32'd1,         32'd1};
        vecs[3]  = '{"sltu", 13'h0008, 32'hFFFF_FFFF, 32'd1,         32'd0};
        vecs[4]  = '{"and",  13'h0010, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000};
        vecs[5]  = '{"nor",  13'h0020, 32'd0,         32'd0,         32'hFFFF_FFFF};
        vecs[6]  = '{"or",   13'h0040, 32'h0F0F_0000, 32'h0000_00FF, 32'h0F0F_00FF};
        vecs[7]  = '{"xor",  13'h0080, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555};
        vecs[8]  = '{"sll",  13'h0100, 32'd1,         32'd31,        32'h8000_0000};
        vecs[9]  = '{"srl",  13'h0200, 32'h8000_0000, 32'd4,         32'h0800_0000};
        vecs[10] = '{"sra",  13'h0400, 32'h8000_0000, 32'd4,         32'hF800_0000};
        vecs[11] = '{"lui",  13'h0800, 32'd9,         32'h1234_5000, 32'h1234_5000};
        vecs[12] = '{"mul_wrap", 13'h1000, 32'h0001_0000, 32'h0001_0000, 32'd0};
        vecs[13] = '{"add_wrap", 13'h0001, 32'hFFFF_FFFF, 32'd2,     32'd1};

        foreach (vecs[i]) begin
            step(1, mk_bus(vecs[i].op, vecs[i].a, vecs[i].b, 32'd0, 5'd1, 1'b1, 1'b0, 1'b0,
                           32'h100 + 32'(i)), 1);
            step(0, '0, 1);
            seen = es_to_ms_valid;
            for (int w = 0; w < 4 && !seen; w++) begin
                step(0, '0, 1);
                seen = es_to_ms_valid;
            end
            chk({vecs[i].name, "_offered"}, 128'(seen), 128'(1));
            chk({vecs[i].name, "_result"}, 128'(es_to_ms_bus[63:32]), 128'(vecs[i].exp));
            step(0, '0, 1);
        end

        // Add: offered the cycle after acceptance
        step(1, mk_bus(13'h0001, 32'd5, 32'd7, 32'd0, 5'd2, 1'b1, 1'b0, 1'b0, 32'h200), 1);
        step(0, '0, 1);
        chk("add_valid", 128'(es_to_ms_valid), 128'(1));
        chk("add_result", 128'(es_to_ms_bus[63:32]), 128'(12));
        chk("add_sram_en", 128'(data_sram_en), 128'(0));

        // Mul: two cycles resident, low product word
        step(1, mk_bus(13'h1000, 32'd3, 32'hFFFF_FFFE, 32'd0, 5'd3, 1'b1, 1'b0, 1'b0, 32'h204), 1);
        step(0, '0, 1);
        chk("mul_c1_valid", 128'(es_to_ms_valid), 128'(0));
        chk("mul_c1_allowin", 128'(es_allowin), 128'(0));
        step(0, '0, 1);
        chk("mul_c2_valid", 128'(es_to_ms_valid), 128'(1));
        chk("mul_c2_result", 128'(es_to_ms_bus[63:32]), 128'(32'hFFFF_FFFA));
        step(0, '0, 1);
        chk("mul_drained", 128'(es_to_ms_valid), 128'(0));

        // Backpressure: held add stays put, the next one waits for ms_allowin
        step(1, mk_bus(13'h0001, 32'd1, 32'd2, 32'd0, 5'd5, 1'b1, 1'b0, 1'b0, 32'h208), 0);
        step(1, mk_bus(13'h0001, 32'd10, 32'd20, 32'd0, 5'd6, 1'b1, 1'b0, 1'b0, 32'h20C), 0);
        chk("bp_allowin", 128'(es_allowin), 128'(0));
        chk("bp_result_a", 128'(es_to_ms_bus[63:32]), 128'(3));
        held = es_to_ms_bus;
        step(1, mk_bus(13'h0001, 32'd10, 32'd20, 32'd0, 5'd6, 1'b1, 1'b0, 1'b0, 32'h20C), 0);
        chk("bp_bus_stable", 128'(es_to_ms_bus), 128'(held));
        step(1, mk_bus(13'h0001, 32'd10, 32'd20, 32'd0, 5'd6, 1'b1, 1'b0, 1'b0, 32'h20C), 1);
        chk("bp_release_allowin", 128'(es_allowin), 128'(1));
        chk("bp_release_a", 128'(es_to_ms_bus[63:32]), 128'(3));
        step(0, '0, 1);
        chk("bp_b_valid", 128'(es_to_ms_valid), 128'(1));
        chk("bp_b_result", 128'(es_to_ms_bus[63:32]), 128'(30));
        chk("bp_b_pc", 128'(es_to_ms_bus[31:0]), 128'(32'h20C));
        step(0, '0, 1);

        // Store: memory request only while the memory stage can take it
        step(1, mk_bus(13'h0001, 32'h1000, 32'd8, 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b1, 1'b0, 32'h210), 0);
        step(0, '0, 0);
        chk("st_stall_en", 128'(data_sram_en), 128'(0));
        chk("st_stall_we", 128'(data_sram_we), 128'(0));
        step(0, '0, 1);
        chk("st_en", 128'(data_sram_en), 128'(1));
        chk("st_we", 128'(data_sram_we), 128'(4'hF));
        chk("st_addr", 128'(data_sram_addr), 128'(32'h1008));
        chk("st_wdata", 128'(data_sram_wdata), 128'(32'hDEAD_BEEF));
        step(0, '0, 1);
        chk("st_once", 128'(data_sram_en), 128'(0));

        // Load forward flags while held
        step(1, mk_bus(13'h0001, 32'h2000, 32'd4, 32'd0, 5'd4, 1'b1, 1'b0, 1'b1, 32'h214), 0);
        step(0, '0, 0);
        chk("ld_fwd_flags", 128'(es_fwd_bus[38:37]), 128'(2'b11));
        chk("ld_fwd_dest", 128'(es_fwd_bus[36:32]), 128'(4));
        chk("ld_fwd_result", 128'(es_fwd_bus[31:0]), 128'(32'h2004));
        chk("ld_sram_we", 128'(data_sram_we), 128'(0));
        step(0, '0, 1);
        chk("ld_en", 128'(data_sram_en), 128'(1));
        step(0, '0, 1);

        // Reset in the first mul cycle discards the instruction
        step(1, mk_bus(13'h1000, 32'd3, 32'd4, 32'd0, 5'd7, 1'b1, 1'b0, 1'b0, 32'h218), 1);
        step(0, '0, 1);
        reset = 1'b1;
        chk("rm_c1_en", 128'(data_sram_en), 128'(0));
        step(0, '0, 1);
        reset = 1'b0;
        md = dut.mul_done;
        chk("rm_es_valid", 128'(dut.es_valid), 128'(0));
        chk("rm_mul_done", 128'(md), 128'(0));
        chk("rm_allowin", 128'(es_allowin), 128'(1));
        chk("rm_to_ms_valid", 128'(es_to_ms_valid), 128'(0));
        chk("rm_en", 128'(data_sram_en), 128'(0));
        step(0, '0, 1);
        chk("rm_still_idle", 128'(es_to_ms_valid), 128'(0));

        // Randomized traffic against the behavioural model
        m_valid = 1'b0;
        m_mul = 1'b0;
        m_cyc = 0;
        m_payload = '0;
        m_memop = 1'b0;
        m_mem_we = 1'b0;
        m_gr_we = 1'b0;
        m_rfm = 1'b0;
        m_rkd = '0;
        m_dest = '0;
        for (int c = 0; c < 3000; c++) begin
            logic [12:0] op;
            logic [31:0] a;
            logic [31:0] b;
            logic [31:0] rkd;
            logic [31:0] pc;
            logic [4:0]  dest;
            logic        v;
            logic        msa;
            logic        gw;
            logic        mw;
            logic        rf;
            logic        ready;
            logic        exp_allowin;
            logic        exp_en;
            int          k;
            int          kind;

            k    = $urandom_range(0, 12);
            op   = 13'd1 << k;
            a    = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            b    = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            rkd  = $urandom;
            pc   = $urandom;
            dest = 5'($urandom_range(0, 31));
            kind = (k == 12) ? 0 : $urandom_range(0, 3);
            gw   = (kind == 2) || (kind == 3) || ((kind == 0) && ($urandom_range(0, 1) == 1));
            mw   = (kind == 1);
            rf   = (kind == 2);
            v    = ($urandom_range(0, 3) != 0);
            msa  = ($urandom_range(0, 3) != 0);
            step(v, mk_bus(op, a, b, rkd, dest, gw, mw, rf, pc), msa);

            ready       = !m_mul || (m_cyc >= 2);
            exp_allowin = !m_valid || (ready && msa);
            exp_en      = m_valid && m_memop && msa;
            chk("rnd_to_ms_valid", 128'(es_to_ms_valid), 128'(m_valid && ready));
            chk("rnd_allowin", 128'(es_allowin), 128'(exp_allowin));
            chk("rnd_sram_en", 128'(data_sram_en), 128'(exp_en));
            chk("rnd_sram_we", 128'(data_sram_we), 128'({4{m_mem_we && exp_en}}));
            chk("rnd_fwd_flags", 128'(es_fwd_bus[38:37]),
                128'({m_valid && m_gr_we, m_valid && m_rfm}));
            if (m_valid && ready) begin
                chk("rnd_ms_bus", 128'(es_to_ms_bus), 128'(m_payload));
                chk("rnd_fwd_data", 128'(es_fwd_bus[36:0]), 128'({m_dest, m_payload[63:32]}));
            end
            if (exp_en) begin
                chk("rnd_sram_addr", 128'(data_sram_addr), 128'(m_payload[63:32]));
                chk("rnd_sram_wdata", 128'(data_sram_wdata), 128'(m_rkd));
            end

            if (exp_allowin) begin
                m_valid = v;
                if (v) begin
                    m_mul     = (k == 12);
                    m_cyc     = 1;
                    m_payload = {rf, gw, dest, ref_alu(op, a, b), pc};
                    m_memop   = mw || rf;
                    m_mem_we  = mw;
                    m_gr_we   = gw;
                    m_rfm     = rf;
                    m_rkd     = rkd;
                    m_dest    = dest;
                end
            end else begin
                m_cyc++;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
